// File: rtl/serial_adder_ctrl.sv
// rtl/serial_adder_ctrl.sv - bit-serial adder controller driving an external 1-bit full adder
module serial_adder_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             fa_add1,
   output logic             fa_add2,
   output logic             fa_cin,
   input  logic             fa_sum,
   input  logic             fa_cout,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] sum_sh;
   logic [WIDTH-1:0] sum_sh_nxt;
   logic [CW-1:0]    cnt;
   logic             carry;
   logic             last_bit;
   logic [WIDTH-1:0] sum_q;
   logic             cout_q;
   logic             done_q;

   assign last_bit   = (cnt == CW'(WIDTH - 1));
   assign sum_sh_nxt = {fa_sum, sum_sh[WIDTH-1:1]};

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state decode; the adder stage only sees live bits while RUN
   always_comb begin
      state_nxt = state;
      fa_add1   = 1'b0;
      fa_add2   = 1'b0;
      fa_cin    = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = RUN;
            end
         end
         RUN: begin
            fa_add1 = a_sh[0];
            fa_add2 = b_sh[0];
            fa_cin  = carry;
            if (last_bit) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Operand shifters, carry, bit counter and result capture
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sh   <= '0;
         b_sh   <= '0;
         sum_sh <= '0;
         cnt    <= '0;
         carry  <= 1'b0;
         sum_q  <= '0;
         cout_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  a_sh   <= a;
                  b_sh   <= b;
                  carry  <= cin;
                  cnt    <= '0;
                  sum_sh <= '0;
                  sum_q  <= '0;
                  cout_q <= 1'b0;
               end
            end
            RUN: begin
               a_sh   <= a_sh >> 1;
               b_sh   <= b_sh >> 1;
               carry  <= fa_cout;
               sum_sh <= sum_sh_nxt;
               // Hold on the final bit so the counter never wraps inside RUN
               if (!last_bit) begin
                  cnt <= cnt + CW'(1);
               end else begin
                  sum_q  <= sum_sh_nxt;
                  cout_q <= fa_cout;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Registered completion pulse, high exactly while in DONE
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         done_q <= 1'b0;
      end else begin
         done_q <= (state_nxt == DONE);
      end
   end

   assign busy = (state != IDLE);
   assign done = done_q;
   assign sum  = sum_q;
   assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb/tb_serial_adder_ctrl.sv - directed bench for serial_adder_ctrl with a full adder attached
module tb_serial_adder_ctrl;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [7:0] a;
   logic [7:0] b;
   logic       cin;
   logic       fa_add1;
   logic       fa_add2;
   logic       fa_cin;
   logic       fa_s;
   logic       fa_c;
   logic       busy;
   logic       done;
   logic [7:0] sum;
   logic       cout;

   int errors = 0;
   int checks = 0;

   // 1-bit full adder stage
   assign fa_s = fa_add1 ^ fa_add2 ^ fa_cin;
   assign fa_c = (fa_add1 & fa_add2) | (fa_add1 & fa_cin) | (fa_add2 & fa_cin);

   serial_adder_ctrl #(.WIDTH(8)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .a       (a),
      .b       (b),
      .cin     (cin),
      .fa_add1 (fa_add1),
      .fa_add2 (fa_add2),
      .fa_cin  (fa_cin),
      .fa_sum  (fa_s),
      .fa_cout (fa_c),
      .busy    (busy),
      .done    (done),
      .sum     (sum),
      .cout    (cout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One addition; poke >= 0 pulses start with a=FF during that RUN cycle index
   task automatic run_add(input logic [7:0] ta, input logic [7:0] tb_v, input logic tc,
                          input logic [7:0] es, input logic ec, input int poke, input string tag);
      int n;
      int bcnt;
      @(negedge clk);
      a = ta; b = tb_v; cin = tc; start = 1'b1;
      @(negedge clk);
      start = 1'b0; a = ~ta; b = ~tb_v; cin = ~tc;
      check({tag, "_sum_clr"}, {24'd0, sum}, 32'd0);
      check({tag, "_busy0"}, {31'd0, busy}, 32'd1);
      n = 0;
      bcnt = busy ? 1 : 0;
      while (done !== 1'b1 && n < 20) begin
         start = (n == poke);
         if (n == poke) a = 8'hFF;
         @(negedge clk);
         n++;
         if (busy) bcnt++;
      end
      start = 1'b0;
      check({tag, "_latency"}, n, 32'd8);
      check({tag, "_busy_cycles"}, bcnt, 32'd9);
      check({tag, "_sum"}, {24'd0, sum}, {24'd0, es});
      check({tag, "_cout"}, {31'd0, cout}, {31'd0, ec});
      @(negedge clk);
      check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
      check({tag, "_idle"}, {31'd0, busy}, 32'd0);
      check({tag, "_hold"}, {23'd0, cout, sum}, {23'd0, ec, es});
   endtask

   initial begin
      int dcnt;
      int prev;
      int pulses;
      rst_n = 1'b0; start = 1'b0; a = 8'hA5; b = 8'h3C; cin = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_sum", {23'd0, cout, sum}, 32'd0);
      check("rst_fa", {29'd0, fa_add1, fa_add2, fa_cin}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("idle_fa", {29'd0, fa_add1, fa_add2, fa_cin}, 32'd0);

      // Basic additions and carry ripple extremes
      run_add(8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0, -1, "t1");
      run_add(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, -1, "t2");
      run_add(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, -1, "t3a");
      run_add(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, -1, "t3b");
      run_add(8'hC3, 8'h5E, 1'b1, 8'h22, 1'b1, -1, "t3c");

      // start pulsed mid-RUN must be ignored
      run_add(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 2, "t4");
      dcnt = 0;
      repeat (12) begin
         @(negedge clk);
         if (done) dcnt++;
      end
      check("t4_extra_done", dcnt, 32'd0);
      check("t4_idle", {31'd0, busy}, 32'd0);

      // Asynchronous reset in RUN cycle 4
      @(negedge clk);
      a = 8'h77; b = 8'h66; cin = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      check("t5_busy_pre", {31'd0, busy}, 32'd1);
      rst_n = 1'b0;
      #1;
      check("t5_busy", {31'd0, busy}, 32'd0);
      check("t5_done", {31'd0, done}, 32'd0);
      check("t5_sum", {23'd0, cout, sum}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      dcnt = 0;
      repeat (12) begin
         @(negedge clk);
         if (done) dcnt++;
      end
      check("t5_no_done", dcnt, 32'd0);
      run_add(8'h01, 8'h02, 1'b0, 8'h03, 1'b0, -1, "t5b");

      // start held high: back-to-back operations every 10 cycles
      @(negedge clk);
      a = 8'h01; b = 8'h01; cin = 1'b0; start = 1'b1;
      prev = -1;
      pulses = 0;
      for (int i = 0; i < 45; i++) begin
         @(negedge clk);
         if (done) begin
            pulses++;
            check("t6_sum", {23'd0, cout, sum}, 32'h002);
            if (prev >= 0) check("t6_period", i - prev, 32'd10);
            prev = i;
         end
      end
      start = 1'b0;
      check("t6_pulses", pulses, 32'd4);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
